// File: rtl/rx_pkg.sv
// Shared receive-path definitions: FSM state encoding and the byte width
// used by both the bit-stuffing controller and the byte assembler.
package rx_pkg;

  localparam int RX_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_byte_fifo.sv
// Two-entry byte buffer between the assembler and the downstream consumer.
// A push into a full buffer is accepted only when a pop happens in the same
// cycle; otherwise it is ignored and the caller flags the loss.
module rx_byte_fifo
  import rx_pkg::*;
#(
  parameter int W = RX_BYTE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem_q [0:1];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  // qualify requests against current occupancy
  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
  end

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

endmodule

// File: rtl/rx_byte_assembler.sv
// Collects destuffed serial bits LSB-first into bytes, buffers them for the
// consumer and reports per-packet length, misalignment and buffer loss.
//
// state | meaning
// IDLE  | waiting for packet_active; strobes ignored
// RECV  | packet body, sr_enable shifts bits in (including the falling cycle)
// DONE  | one-cycle packet summary: pkt_done, pkt_len, align_err valid
module rx_byte_assembler
  import rx_pkg::*;
#(
  parameter  int BYTE_W    = RX_BYTE_W,
  parameter  int MAX_BYTES = 64,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_orig,
  input  logic              sr_enable,
  input  logic              packet_active,
  input  logic              clear_errors,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              pkt_done,
  output logic              align_err,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              overflow
);

  localparam int CNT_W = $clog2(BYTE_W);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
  logic              pkt_done_q, pkt_done_d;
  logic              align_err_q, align_err_d;
  logic              overflow_q, overflow_d;

  logic              shift_en;
  logic              byte_done;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      byte_cnt_q  <= '0;
      pkt_len_q   <= '0;
      pkt_done_q  <= 1'b0;
      align_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      byte_cnt_q  <= byte_cnt_d;
      pkt_len_q   <= pkt_len_d;
      pkt_done_q  <= pkt_done_d;
      align_err_q <= align_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // next-state decode from packet framing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (packet_active)  state_d = RECV;
      RECV:    if (!packet_active) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bit shifting, byte counting and registered status outputs
  always_comb begin
    shift_en    = (state_q == RECV) && sr_enable;
    byte_done   = shift_en && (bit_cnt_q == CNT_W'(BYTE_W - 1));
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    byte_cnt_d  = byte_cnt_q;
    fifo_pop    = byte_ready && !fifo_empty;
    overflow_d  = overflow_q;

    if ((state_q == IDLE) && packet_active) begin
      bit_cnt_d  = '0;
      shreg_d    = '0;
      byte_cnt_d = '0;
    end

    if (shift_en) begin
      shreg_d   = {d_orig, shreg_q[BYTE_W-1:1]};
      bit_cnt_d = byte_done ? '0 : bit_cnt_q + CNT_W'(1);
    end

    if (byte_done && (byte_cnt_q != LEN_W'(MAX_BYTES))) begin
      byte_cnt_d = byte_cnt_q + LEN_W'(1);
    end

    // the byte finishing on the last RECV cycle still counts toward pkt_len
    pkt_done_d  = (state_q == RECV) && !packet_active;
    align_err_d = pkt_done_d && (bit_cnt_d != '0);
    pkt_len_d   = pkt_done_d ? byte_cnt_d : pkt_len_q;

    // a lost byte outranks a simultaneous clear so the loss is never hidden
    if (byte_done && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end else if (clear_errors) begin
      overflow_d = 1'b0;
    end
  end

  rx_byte_fifo #(
    .W(BYTE_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (byte_done),
    .pop  (fifo_pop),
    .din  (shreg_d),
    .dout (byte_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign byte_valid = !fifo_empty;
  assign pkt_done   = pkt_done_q;
  assign align_err  = align_err_q;
  assign pkt_len    = pkt_len_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Bench for rx_byte_assembler: directed scenarios followed by randomized
// packets, every cycle compared against a queue-based packet model.
module tb_rx_byte_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_orig;
  logic       sr_enable;
  logic       packet_active;
  logic       clear_errors;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       pkt_done;
  logic       align_err;
  logic [6:0] pkt_len;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  bit rnd_mode = 1'b0;

  // reference model state
  int         m_phase;   // 0 idle, 1 receiving, 2 summary cycle
  int         m_nbits;
  int         m_acc;
  int         m_cnt;
  int         m_len;
  bit         m_done;
  bit         m_align;
  bit         m_ov;
  logic [7:0] m_fifo [$];

  always #5 clk = ~clk;

  rx_byte_assembler dut (
    .clk          (clk),
    .rst          (rst),
    .d_orig       (d_orig),
    .sr_enable    (sr_enable),
    .packet_active(packet_active),
    .clear_errors (clear_errors),
    .byte_ready   (byte_ready),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .pkt_done     (pkt_done),
    .align_err    (align_err),
    .pkt_len      (pkt_len),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step();
    bit         pop;
    bit         comp;
    bit         drop;
    logic [7:0] nb;
    nb = 8'h00;
    if (rst) begin
      m_phase = 0; m_nbits = 0; m_acc = 0; m_cnt = 0; m_len = 0;
      m_done = 0; m_align = 0; m_ov = 0;
      m_fifo.delete();
      return;
    end
    pop     = byte_ready && (m_fifo.size() > 0);
    comp    = 0;
    m_done  = 0;
    m_align = 0;
    case (m_phase)
      0: if (packet_active) begin
        m_phase = 1; m_nbits = 0; m_acc = 0; m_cnt = 0;
      end
      1: begin
        if (sr_enable) begin
          m_acc = m_acc + ((d_orig ? 1 : 0) << m_nbits);
          m_nbits++;
          if (m_nbits == 8) begin
            comp    = 1;
            nb      = 8'(m_acc);
            m_nbits = 0;
            m_acc   = 0;
            if (m_cnt < 64) m_cnt++;
          end
        end
        if (!packet_active) begin
          m_phase = 2;
          m_done  = 1;
          m_align = (m_nbits != 0);
          m_len   = m_cnt;
        end
      end
      default: m_phase = 0;
    endcase
    drop = comp && (m_fifo.size() == 2) && !pop;
    if (pop) void'(m_fifo.pop_front());
    if (comp && !drop) m_fifo.push_back(nb);
    if (drop) m_ov = 1;
    else if (clear_errors) m_ov = 0;
  endfunction

  task automatic check_all();
    chk("byte_valid", 32'(byte_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) chk("byte_data", 32'(byte_data), 32'(m_fifo[0]));
    chk("pkt_done", 32'(pkt_done), 32'(m_done));
    chk("align_err", 32'(align_err), 32'(m_align));
    chk("pkt_len", 32'(pkt_len), 32'(m_len));
    chk("overflow", 32'(overflow), 32'(m_ov));
  endtask

  task automatic step();
    if (rnd_mode) begin
      byte_ready   = ($urandom_range(0, 3) != 0);
      clear_errors = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic send_bit(input logic b, input int gap);
    sr_enable = 1'b0;
    for (int g = 0; g < gap; g++) step();
    sr_enable = 1'b1;
    d_orig    = b;
    step();
    sr_enable = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap);
  endtask

  task automatic end_packet();
    packet_active = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] v;
    int         nb;
    rst = 1'b1; d_orig = 1'b0; sr_enable = 1'b0; packet_active = 1'b0;
    clear_errors = 1'b0; byte_ready = 1'b0;

    // reset values
    repeat (2) step();
    chk("rst_byte_data", 32'(byte_data), 32'h0);
    chk("rst_pkt_len", 32'(pkt_len), 32'h0);
    rst = 1'b0;
    step();

    // two bytes, strobe every 4th cycle, consumer always ready
    byte_ready = 1'b1;
    packet_active = 1'b1; step();
    send_byte(8'hA5, 3);
    chk("tp1_first_valid", 32'(byte_valid), 32'h1);
    chk("tp1_first_data", 32'(byte_data), 32'hA5);
    send_byte(8'h3C, 3);
    chk("tp1_second_data", 32'(byte_data), 32'h3C);
    end_packet();
    chk("tp1_done", 32'(pkt_done), 32'h1);
    chk("tp1_len", 32'(pkt_len), 32'h2);
    chk("tp1_align", 32'(align_err), 32'h0);
    step();

    // 0xFF with a stuffed slot in the middle
    packet_active = 1'b1; step();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    step();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    chk("tp2_data", 32'(byte_data), 32'hFF);
    end_packet();
    chk("tp2_len", 32'(pkt_len), 32'h1);
    step();

    // 11 bits, the 11th taken on the falling cycle
    packet_active = 1'b1; step();
    send_byte(8'h96, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    packet_active = 1'b0; sr_enable = 1'b1; d_orig = 1'b1;
    step();
    sr_enable = 1'b0;
    chk("tp3_done", 32'(pkt_done), 32'h1);
    chk("tp3_align", 32'(align_err), 32'h1);
    chk("tp3_len", 32'(pkt_len), 32'h1);
    step();
    step();
    chk("tp3_align_pulse", 32'(align_err), 32'h0);

    // overflow with consumer stalled, then drain and clear
    byte_ready = 1'b0;
    packet_active = 1'b1; step();
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 1);
    chk("tp4_ovf", 32'(overflow), 32'h1);
    chk("tp4_head", 32'(byte_data), 32'h01);
    end_packet(); step();
    byte_ready = 1'b1; step();
    chk("tp4_second", 32'(byte_data), 32'h02);
    step();
    chk("tp4_empty", 32'(byte_valid), 32'h0);
    byte_ready = 1'b0; clear_errors = 1'b1; step();
    clear_errors = 1'b0;
    chk("tp4_clear", 32'(overflow), 32'h0);

    // completion coinciding with a pop while full
    packet_active = 1'b1; step();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    v = 8'h33;
    for (int i = 0; i < 7; i++) send_bit(v[i], 0);
    byte_ready = 1'b1;
    send_bit(v[7], 0);
    chk("tp5_no_ovf", 32'(overflow), 32'h0);
    chk("tp5_head", 32'(byte_data), 32'h22);
    step();
    chk("tp5_third", 32'(byte_data), 32'h33);
    end_packet(); step();

    // asynchronous reset mid-packet, then a clean packet while active stays high
    byte_ready = 1'b0;
    packet_active = 1'b1; step();
    send_byte(8'h5A, 0);
    send_byte(8'h6B, 0);
    send_byte(8'h7C, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    rst = 1'b1;
    #1;
    chk("tp6_valid", 32'(byte_valid), 32'h0);
    chk("tp6_data", 32'(byte_data), 32'h0);
    chk("tp6_ovf", 32'(overflow), 32'h0);
    chk("tp6_len", 32'(pkt_len), 32'h0);
    chk("tp6_done", 32'(pkt_done), 32'h0);
    chk("tp6_align", 32'(align_err), 32'h0);
    step();
    rst = 1'b0; byte_ready = 1'b1;
    step();
    send_byte(8'hC3, 1);
    chk("tp6_after", 32'(byte_data), 32'hC3);
    end_packet();
    chk("tp6_len_after", 32'(pkt_len), 32'h1);
    chk("tp6_align_after", 32'(align_err), 32'h0);
    step();

    // byte-count saturation
    packet_active = 1'b1; step();
    for (int i = 0; i < 66; i++) send_byte(8'(i * 7 + 1), 0);
    end_packet();
    chk("tp7_sat_len", 32'(pkt_len), 32'd64);
    step();

    // randomized packets, some back-to-back through the summary cycle
    rnd_mode = 1'b1;
    for (int p = 0; p < 30; p++) begin
      packet_active = 1'b1; step();
      nb = $urandom_range(0, 40);
      for (int b = 0; b < nb; b++) begin
        if (b == nb - 1 && $urandom_range(0, 1) == 1) begin
          packet_active = 1'b0;
          sr_enable = 1'b1;
          d_orig = 1'($urandom_range(0, 1));
          step();
          sr_enable = 1'b0;
        end else begin
          send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
      end
      if (packet_active) end_packet();
      packet_active = 1'($urandom_range(0, 1));
      step();
    end
    rnd_mode = 1'b0;
    packet_active = 1'b0; clear_errors = 1'b0; byte_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_byte_assembler.md
# rx_byte_assembler

Receive-path stage directly downstream of the decode bit-stuffing controller. It consumes the destuffed serial bit (`d_orig`) qualified by the stuffing-gated shift enable (`sr_enable`). It assembles bits LSB-first into bytes and presents them on a valid/ready interface through a 2-entry buffer. It also reports per-packet byte length, misaligned end-of-packet, and buffer overflow to the receive controller.

## Interface
- `BYTE_W`, 8, bits per assembled byte
- `MAX_BYTES`, 64, packet byte-count saturation value; `pkt_len` width is `$clog2(MAX_BYTES+1)`

- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  reset; **asynchronous, active-high**
- `d_orig`  input  1  destuffed received bit
- `sr_enable`  input  1  one-cycle strobe: sample `d_orig` this cycle (already low during stuffed bits)
- `packet_active`  input  1  high for the packet body, from the framing stage
- `clear_errors`  input  1  clears sticky `overflow`
- `byte_ready`  input  1  consumer accepts `byte_data` this cycle
- `byte_data`  output  BYTE_W  head-of-buffer byte
- `byte_valid`  output  1  buffer non-empty
- `pkt_done`  output  1  one-cycle pulse at end of packet
- `align_err`  output  1  one-cycle pulse with `pkt_done` when the partial-byte bit count is nonzero
- `pkt_len`  output  clog2(MAX_BYTES+1)  bytes completed in the last packet, saturating
- `overflow`  output  1  sticky: a completed byte was dropped

## Operation
- FSM states: IDLE, RECV, DONE.
  - IDLE → RECV when `packet_active`=1. Entering RECV clears `bit_cnt`, the shift register, and the running byte count.
  - RECV → DONE when `packet_active`=0.
  - DONE → IDLE unconditionally after 1 cycle.
- `sr_enable` is honoured only in RECV, including the cycle in which `packet_active` falls; that bit is taken. It is ignored in IDLE and DONE.
- Shift on `sr_enable`: shift register shifts right, `d_orig` enters the MSB, so the first bit received ends up in bit 0. `bit_cnt` increments modulo BYTE_W.
- Byte completion: `sr_enable` while `bit_cnt`=BYTE_W-1.
  - The assembled byte (including the current bit) is pushed to the buffer.
  - `bit_cnt` becomes 0.
  - The running byte count increments, saturating at MAX_BYTES.
- DONE cycle:
  - `pkt_done`=1.
  - `pkt_len` is loaded with the running count.
  - `align_err`=1 iff `bit_cnt`≠0. The partial byte is discarded, never pushed.
- Buffer: 2-entry FIFO.
  - Pop when `byte_valid && byte_ready`.
  - Push on byte completion.
  - Push and pop in the same cycle: both take effect. When full, the pop frees the slot, so there is no overflow.
  - Push when full and no pop: the byte is dropped, `overflow` is set, and buffer contents are unchanged.
- `overflow` clears on `clear_errors`. If set and clear occur in the same cycle, set wins.
- `rst` mid-packet: state → IDLE, buffer emptied, counters and errors cleared. A still-high `packet_active` after reset starts a new packet from bit 0.

## Timing
- Reset values: `byte_data`=0, `byte_valid`=0, `pkt_done`=0, `align_err`=0, `pkt_len`=0, `overflow`=0. State IDLE, `bit_cnt`=0.
- Latency: `byte_valid` rises 1 cycle after the completing `sr_enable` edge when the buffer was empty.
- `byte_data` is stable while `byte_valid`=1 and `byte_ready`=0.
- `pkt_done` asserts in the cycle after `packet_active` is sampled low in RECV.
- Minimum inter-packet gap: 1 cycle (DONE). `packet_active` high during DONE is seen in IDLE on the following cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `rx_pkg`: state enum typedef (IDLE, RECV, DONE) and the `RX_BYTE_W` = 8 constant, shared with the bit-stuffing controller.
- Sub-module `rx_byte_fifo`: 2-entry, BYTE_W-wide FIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, empty, full.
  - Asynchronous active-high reset.

## Test plan
- Send 16 bits LSB-first for bytes 0xA5 then 0x3C with `sr_enable` every 4th cycle, `byte_ready`=1 → `byte_data` 0xA5 then 0x3C, each valid 1 cycle after its 8th strobe. On `packet_active` fall: `pkt_done`=1, `pkt_len`=2, `align_err`=0.
- Send 8 bits of 0xFF with `sr_enable` held low for one stuffed-bit slot mid-byte → byte 0xFF. The stuffed slot does not count toward `bit_cnt`.
- Send 11 bits, then drop `packet_active` → one byte delivered, `pkt_len`=1, `align_err` pulse with `pkt_done`.
- Hold `byte_ready`=0 and send 3 bytes (0x01, 0x02, 0x03) → 0x01 and 0x02 buffered, `overflow`=1. Release ready → 0x01 then 0x02. Assert `clear_errors` → `overflow`=0.
- With the buffer full, complete a byte in the same cycle as a pop → no overflow, and the new byte is delivered third.
- Assert `rst` after 5 bits of a packet → all outputs return to reset values within the same cycle. The next packet's first byte assembles correctly from bit 0.
